// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// Optional perf counters: define MULTICYCLE_PERF_CNT_EN.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    EXECU    = 4'd8,
    ALUWB    = 4'd9,
    BRANCH   = 4'd10,
    JAL      = 4'd11,
    JALR     = 4'd12,
    JALR2    = 4'd13,
    ILLEGAL  = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [2:0] ALUOP_R  = 3'b000;
  localparam logic [2:0] ALUOP_B  = 3'b001;
  localparam logic [2:0] ALUOP_LS = 3'b010;
  localparam logic [2:0] ALUOP_I  = 3'b011;
  localparam logic [2:0] ALUOP_U  = 3'b100;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/multicycle_control_fsm_opcode_class_decoder.sv
// Opcode/funct3 classifier: picks the state that follows DECODE.
// Pure combinational; no perf-counter (MULTICYCLE_PERF_CNT_EN) dependence.
module opcode_class_decoder
  import multicycle_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  output state_t     next_state_o
);

  logic br_ok;

  assign br_ok = (funct3_i == F3_BEQ) ||
                 (funct3_i == F3_BNE);

  always_comb begin
    next_state_o = ILLEGAL;
    unique case (opcode_i)
      OP_LOAD,
      OP_STORE:  next_state_o = MEMADR;
      OP_R:      next_state_o = EXECR;
      OP_I:      next_state_o = EXECI;
      OP_BRANCH: next_state_o = br_ok ? BRANCH
                                      : ILLEGAL;
      OP_JAL:    next_state_o = JAL;
      OP_JALR:   next_state_o = JALR;
      OP_LUI,
      OP_AUIPC:  next_state_o = EXECU;
      default:   next_state_o = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core.
// Define MULTICYCLE_PERF_CNT_EN for cycle/instret counters.
module multicycle_control_fsm
  import multicycle_pkg::*;
#(
  parameter state_t RESET_STATE = FETCH
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUOp,
  output logic       illegal_instr
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
`endif
);

  state_t state_q, state_d, dec_next;

  logic       pcw, adr, mw, irw, rw, ill;
  logic [1:0] res, srca, srcb;
  logic [2:0] imm, aluop;

  opcode_class_decoder u_dec (
    .opcode_i     (opcode),
    .funct3_i     (funct3),
    .next_state_o (dec_next)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pcw     = 1'b0;
    adr     = 1'b0;
    mw      = 1'b0;
    irw     = 1'b0;
    rw      = 1'b0;
    ill     = 1'b0;
    res     = RES_ALUOUT;
    srca    = SRCA_PC;
    srcb    = SRCB_RS2;
    imm     = IMM_I;
    aluop   = ALUOP_R;
    unique case (state_q)
      FETCH: begin
        srca  = SRCA_PC;
        srcb  = SRCB_FOUR;
        aluop = ALUOP_LS;
        res   = RES_ALURES;
        irw   = mem_ready;
        pcw   = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        // Branch target precomputed here; JAL uses the J immediate
        srca    = SRCA_OLDPC;
        srcb    = SRCB_IMM;
        aluop   = ALUOP_LS;
        imm     = (opcode == OP_JAL) ? IMM_J : IMM_B;
        state_d = dec_next;
      end
      MEMADR: begin
        srca    = SRCA_RS1;
        srcb    = SRCB_IMM;
        aluop   = ALUOP_LS;
        imm     = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_d = (opcode == OP_STORE) ? MEMWRITE
                                       : MEMREAD;
      end
      MEMREAD: begin
        adr = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        res     = RES_DATA;
        rw      = 1'b1;
        state_d = FETCH;
      end
      MEMWRITE: begin
        adr = 1'b1;
        mw  = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      EXECR: begin
        srca    = SRCA_RS1;
        srcb    = SRCB_RS2;
        aluop   = ALUOP_R;
        state_d = ALUWB;
      end
      EXECI: begin
        srca    = SRCA_RS1;
        srcb    = SRCB_IMM;
        imm     = IMM_I;
        aluop   = ALUOP_I;
        state_d = ALUWB;
      end
      EXECU: begin
        srca    = (opcode == OP_LUI) ? SRCA_ZERO
                                     : SRCA_OLDPC;
        srcb    = SRCB_IMM;
        imm     = IMM_U;
        aluop   = ALUOP_U;
        state_d = ALUWB;
      end
      ALUWB: begin
        res     = RES_ALUOUT;
        rw      = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        srca    = SRCA_RS1;
        srcb    = SRCB_RS2;
        aluop   = ALUOP_B;
        res     = RES_ALUOUT;
        pcw     = ((funct3 == F3_BEQ) &&  zero) ||
                  ((funct3 == F3_BNE) && !zero);
        state_d = FETCH;
      end
      JAL, JALR2: begin
        // Jump target from ALUOut; link oldPC+4 goes to ALUWB
        res     = RES_ALUOUT;
        pcw     = 1'b1;
        srca    = SRCA_OLDPC;
        srcb    = SRCB_FOUR;
        aluop   = ALUOP_LS;
        state_d = ALUWB;
      end
      JALR: begin
        srca    = SRCA_RS1;
        srcb    = SRCB_IMM;
        imm     = IMM_I;
        aluop   = ALUOP_LS;
        state_d = JALR2;
      end
      ILLEGAL: begin
        ill     = 1'b1;
        state_d = ILLEGAL;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset gates every output so strobes drop without a clock edge
  assign PCWrite       = RST_n & pcw;
  assign AdrSrc        = RST_n & adr;
  assign MemWrite      = RST_n & mw;
  assign IRWrite       = RST_n & irw;
  assign RegWrite      = RST_n & rw;
  assign illegal_instr = RST_n & ill;
  assign ResultSrc     = RST_n ? res   : 2'b00;
  assign ALUSrcA       = RST_n ? srca  : 2'b00;
  assign ALUSrcB       = RST_n ? srcb  : 2'b00;
  assign ImmSrc        = RST_n ? imm   : 3'b000;
  assign ALUOp         = RST_n ? aluop : 3'b000;

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cyc_q, cyc_d, ret_q, ret_d;
  logic        retire;

  assign retire = (state_d == FETCH) &&
                  (state_q inside {MEMWB, MEMWRITE,
                                   ALUWB, BRANCH});
  assign cyc_d  = cyc_q + 32'd1;
  assign ret_d  = retire ? ret_q + 32'd1 : ret_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cyc_q <= 32'd0;
      ret_q <= 32'd0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign cycle_count   = cyc_q;
  assign instret_count = ret_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm.
// Counter checks compile in with MULTICYCLE_PERF_CNT_EN.
module tb_multicycle_control_fsm;
  import multicycle_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUOp;
  logic       illegal_instr;
`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cycle_count, instret_count;
`endif

  always #5 CLK = ~CLK;

  multicycle_control_fsm dut (
    .CLK           (CLK),
    .RST_n         (RST_n),
    .opcode        (opcode),
    .funct3        (funct3),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .PCWrite       (PCWrite),
    .AdrSrc        (AdrSrc),
    .MemWrite      (MemWrite),
    .IRWrite       (IRWrite),
    .RegWrite      (RegWrite),
    .ResultSrc     (ResultSrc),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ImmSrc        (ImmSrc),
    .ALUOp         (ALUOp),
    .illegal_instr (illegal_instr)
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    .cycle_count   (cycle_count),
    .instret_count (instret_count)
`endif
  );

  // {PCW,Adr,MW,IRW,RW,Res[2],A[2],B[2],Imm[3],Op[3],Ill}
  localparam logic [17:0] E_RST  = 18'b0_0_0_0_0_00_00_00_000_000_0;
  localparam logic [17:0] E_F1   = 18'b1_0_0_1_0_10_00_10_000_010_0;
  localparam logic [17:0] E_F0   = 18'b0_0_0_0_0_10_00_10_000_010_0;
  localparam logic [17:0] E_DB   = 18'b0_0_0_0_0_00_01_01_010_010_0;
  localparam logic [17:0] E_DJ   = 18'b0_0_0_0_0_00_01_01_100_010_0;
  localparam logic [17:0] E_MAL  = 18'b0_0_0_0_0_00_10_01_000_010_0;
  localparam logic [17:0] E_MAS  = 18'b0_0_0_0_0_00_10_01_001_010_0;
  localparam logic [17:0] E_MRD  = 18'b0_1_0_0_0_00_00_00_000_000_0;
  localparam logic [17:0] E_MWB  = 18'b0_0_0_0_1_01_00_00_000_000_0;
  localparam logic [17:0] E_MWR  = 18'b0_1_1_0_0_00_00_00_000_000_0;
  localparam logic [17:0] E_XR   = 18'b0_0_0_0_0_00_10_00_000_000_0;
  localparam logic [17:0] E_XI   = 18'b0_0_0_0_0_00_10_01_000_011_0;
  localparam logic [17:0] E_LUI  = 18'b0_0_0_0_0_00_11_01_011_100_0;
  localparam logic [17:0] E_AUI  = 18'b0_0_0_0_0_00_01_01_011_100_0;
  localparam logic [17:0] E_AWB  = 18'b0_0_0_0_1_00_00_00_000_000_0;
  localparam logic [17:0] E_BT   = 18'b1_0_0_0_0_00_10_00_000_001_0;
  localparam logic [17:0] E_BN   = 18'b0_0_0_0_0_00_10_00_000_001_0;
  localparam logic [17:0] E_JMP  = 18'b1_0_0_0_0_00_01_10_000_010_0;
  localparam logic [17:0] E_JR   = 18'b0_0_0_0_0_00_10_01_000_010_0;
  localparam logic [17:0] E_ILL  = 18'b0_0_0_0_0_00_00_00_000_000_1;

  localparam logic [6:0] OP_FENCE = 7'b0001111;

  logic [17:0] exp_q[$];
  state_t      st_q[$];
  string       nm_q[$];
  int          errors = 0;
  int          checks = 0;

  logic [17:0] act;
  logic [17:0] m_e;
  state_t      m_s;
  string       m_n;

  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp,
                illegal_instr};

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      m_s = st_q.pop_front();
      m_n = nm_q.pop_front();
      checks++;
      if (act !== m_e) begin
        errors++;
        $display("FAIL %s: outputs=%b expected=%b", m_n, act, m_e);
      end
      checks++;
      if (dut.state_q !== m_s) begin
        errors++;
        $display("FAIL %s.state: got=%0d expected=%0d",
                 m_n, dut.state_q, m_s);
      end
    end
  end

  task automatic step(input logic [6:0] op, input logic [2:0] f3,
                      input logic z, input logic mr,
                      input logic [17:0] e, input state_t s,
                      input string n);
    @(posedge CLK);
    #1;
    opcode    = op;
    funct3    = f3;
    zero      = z;
    mem_ready = mr;
    exp_q.push_back(e);
    st_q.push_back(s);
    nm_q.push_back(n);
  endtask

  task automatic do_reset(input string n);
    @(posedge CLK);
    #1;
    RST_n     = 1'b0;
    mem_ready = 1'b0;
    exp_q.push_back(E_RST);
    st_q.push_back(FETCH);
    nm_q.push_back(n);
    @(negedge CLK);
    #1;
`ifdef MULTICYCLE_PERF_CNT_EN
    checks++;
    if (cycle_count !== 32'd0 || instret_count !== 32'd0) begin
      errors++;
      $display("FAIL %s.cnt: cycle=%0d instret=%0d expected 0 0",
               n, cycle_count, instret_count);
    end
`endif
    RST_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset("reset");

    // fetch stall, then add
    step(OP_R, 3'b000, 0, 0, E_F0,  FETCH,  "fetch.wait");
    step(OP_R, 3'b000, 0, 1, E_F1,  FETCH,  "add.fetch");
    step(OP_R, 3'b000, 1, 0, E_DB,  DECODE, "add.decode");
    step(OP_R, 3'b000, 0, 0, E_XR,  EXECR,  "add.exec");
    step(OP_R, 3'b000, 0, 1, E_AWB, ALUWB,  "add.wb");

    // addi
    step(OP_I, 3'b000, 0, 1, E_F1,  FETCH,  "addi.fetch");
    step(OP_I, 3'b000, 0, 0, E_DB,  DECODE, "addi.decode");
    step(OP_I, 3'b000, 0, 0, E_XI,  EXECI,  "addi.exec");
    step(OP_I, 3'b000, 0, 0, E_AWB, ALUWB,  "addi.wb");

    // lw with three wait cycles in MEMREAD
    step(OP_LOAD, 3'b010, 0, 1, E_F1,  FETCH,   "lw.fetch");
    step(OP_LOAD, 3'b010, 0, 0, E_DB,  DECODE,  "lw.decode");
    step(OP_LOAD, 3'b010, 0, 0, E_MAL, MEMADR,  "lw.adr");
    for (int i = 0; i < 3; i++)
      step(OP_LOAD, 3'b010, 0, 0, E_MRD, MEMREAD, "lw.read.wait");
    step(OP_LOAD, 3'b010, 0, 1, E_MRD, MEMREAD, "lw.read");
    step(OP_LOAD, 3'b010, 0, 0, E_MWB, MEMWB,   "lw.wb");

    // sw
    step(OP_STORE, 3'b010, 0, 1, E_F1,  FETCH,    "sw.fetch");
    step(OP_STORE, 3'b010, 0, 1, E_DB,  DECODE,   "sw.decode");
    step(OP_STORE, 3'b010, 0, 1, E_MAS, MEMADR,   "sw.adr");
    step(OP_STORE, 3'b010, 0, 1, E_MWR, MEMWRITE, "sw.write");

    // beq / bne, both zero values
    step(OP_BRANCH, 3'b000, 1, 1, E_F1, FETCH,  "beq1.fetch");
    step(OP_BRANCH, 3'b000, 1, 0, E_DB, DECODE, "beq1.decode");
    step(OP_BRANCH, 3'b000, 1, 0, E_BT, BRANCH, "beq.taken");
    step(OP_BRANCH, 3'b000, 0, 1, E_F1, FETCH,  "beq0.fetch");
    step(OP_BRANCH, 3'b000, 0, 0, E_DB, DECODE, "beq0.decode");
    step(OP_BRANCH, 3'b000, 0, 0, E_BN, BRANCH, "beq.not");
    step(OP_BRANCH, 3'b001, 0, 1, E_F1, FETCH,  "bne0.fetch");
    step(OP_BRANCH, 3'b001, 0, 0, E_DB, DECODE, "bne0.decode");
    step(OP_BRANCH, 3'b001, 0, 0, E_BT, BRANCH, "bne.taken");
    step(OP_BRANCH, 3'b001, 1, 1, E_F1, FETCH,  "bne1.fetch");
    step(OP_BRANCH, 3'b001, 1, 0, E_DB, DECODE, "bne1.decode");
    step(OP_BRANCH, 3'b001, 1, 0, E_BN, BRANCH, "bne.not");

    // lui / auipc
    step(OP_LUI, 3'b000, 0, 1, E_F1,  FETCH,  "lui.fetch");
    step(OP_LUI, 3'b000, 0, 0, E_DB,  DECODE, "lui.decode");
    step(OP_LUI, 3'b000, 0, 0, E_LUI, EXECU,  "lui.exec");
    step(OP_LUI, 3'b000, 0, 0, E_AWB, ALUWB,  "lui.wb");
    step(OP_AUIPC, 3'b000, 0, 1, E_F1,  FETCH,  "auipc.fetch");
    step(OP_AUIPC, 3'b000, 0, 0, E_DB,  DECODE, "auipc.decode");
    step(OP_AUIPC, 3'b000, 0, 0, E_AUI, EXECU,  "auipc.exec");
    step(OP_AUIPC, 3'b000, 0, 0, E_AWB, ALUWB,  "auipc.wb");

    // jal / jalr
    step(OP_JAL, 3'b000, 0, 1, E_F1,  FETCH,  "jal.fetch");
    step(OP_JAL, 3'b000, 0, 0, E_DJ,  DECODE, "jal.decode");
    step(OP_JAL, 3'b000, 0, 0, E_JMP, JAL,    "jal.jump");
    step(OP_JAL, 3'b000, 0, 0, E_AWB, ALUWB,  "jal.wb");
    step(OP_JALR, 3'b000, 0, 1, E_F1,  FETCH,  "jalr.fetch");
    step(OP_JALR, 3'b000, 0, 0, E_DB,  DECODE, "jalr.decode");
    step(OP_JALR, 3'b000, 0, 0, E_JR,  JALR,   "jalr.adr");
    step(OP_JALR, 3'b000, 0, 0, E_JMP, JALR2,  "jalr.jump");
    step(OP_JALR, 3'b000, 0, 0, E_AWB, ALUWB,  "jalr.wb");

    // reset mid-MEMWRITE
    step(OP_STORE, 3'b010, 0, 1, E_F1,  FETCH,    "swr.fetch");
    step(OP_STORE, 3'b010, 0, 0, E_DB,  DECODE,   "swr.decode");
    step(OP_STORE, 3'b010, 0, 0, E_MAS, MEMADR,   "swr.adr");
    step(OP_STORE, 3'b010, 0, 0, E_MWR, MEMWRITE, "swr.write.wait");
    do_reset("swr.reset");
    step(OP_R, 3'b000, 0, 1, E_F1, FETCH, "post.reset.fetch");
    step(OP_R, 3'b000, 0, 0, E_DB, DECODE, "post.reset.decode");
    step(OP_R, 3'b000, 0, 0, E_XR, EXECR,  "post.reset.exec");
    step(OP_R, 3'b000, 0, 0, E_AWB, ALUWB, "post.reset.wb");

    // unsupported opcode: sticky for 10 cycles
    step(OP_FENCE, 3'b000, 0, 1, E_F1, FETCH,  "fence.fetch");
    step(OP_FENCE, 3'b000, 0, 1, E_DB, DECODE, "fence.decode");
    for (int i = 0; i < 10; i++)
      step(OP_FENCE, 3'b000, i[0], i[1], E_ILL, ILLEGAL, "fence.hold");
    do_reset("fence.reset");

    // unsupported branch funct3
    step(OP_BRANCH, 3'b100, 0, 1, E_F1,  FETCH,   "blt.fetch");
    step(OP_BRANCH, 3'b100, 0, 1, E_DB,  DECODE,  "blt.decode");
    step(OP_BRANCH, 3'b100, 0, 1, E_ILL, ILLEGAL, "blt.ill");
    step(OP_BRANCH, 3'b100, 1, 1, E_ILL, ILLEGAL, "blt.hold");
    do_reset("blt.reset");
    step(OP_I, 3'b000, 0, 1, E_F1, FETCH, "final.fetch");

    repeat (2) @(posedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
